fractal_sync_root_monitor: RTL and testbench
============================================

# fractal_sync_root_monitor

Parametrised monitor for the root of the fractal synchronization tree. It watches N_PORTS master-side ports of the top tree node. Each port gets a per-port responder state machine that runs in a runtime-selectable mode: error mode flags every arriving sync as an error, and root mode answers a sync as a legitimate top-level barrier wake. On top of the basic wake/error response it adds an ack timeout, sticky status, saturating error counters and first-error capture for software diagnosis.

## Interface
Parameters:
- N_PORTS, 2, number of monitored ports (≥1)
- LVL_WIDTH, 1, width of the level field carried with sync
- ID_WIDTH, 1, width of the barrier id field carried with sync
- TO_WIDTH, 8, width of the ack-timeout counter and of timeout_i
- CNT_WIDTH, 8, width of the per-port error counters
- IDX_WIDTH (derived), max(1, $clog2(N_PORTS))

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- sync_i  in  [N_PORTS]  sync request per port
- lvl_i  in  [N_PORTS][LVL_WIDTH]  level qualifying sync_i
- id_i  in  [N_PORTS][ID_WIDTH]  barrier id qualifying sync_i
- ack_i  in  [N_PORTS]  acknowledgement of the response
- wake_o  out  [N_PORTS]  response valid
- error_o  out  [N_PORTS]  response is an error; only high while wake_o is high
- mode_i  in  [N_PORTS]  1 = root mode, 0 = error mode; sampled on sync acceptance
- timeout_i  in  TO_WIDTH  maximum ACK wait in cycles; 0 disables the timeout
- clear_i  in  1  synchronous clear of all status, counters and capture
- err_sticky_o  out  [N_PORTS]  an error response was issued since the last clear
- to_sticky_o  out  [N_PORTS]  an ack timeout occurred
- proto_sticky_o  out  [N_PORTS]  sync_i was seen while the port was not IDLE
- err_cnt_o  out  [N_PORTS][CNT_WIDTH]  error responses issued, saturating
- first_vld_o  out  1  the first-error capture is valid
- first_port_o  out  IDX_WIDTH  port index of the first error
- first_lvl_o  out  LVL_WIDTH  level of the first error
- first_id_o  out  ID_WIDTH  id of the first error
- irq_o  out  1  OR of all sticky bits

## Operation
Per-port Moore FSM with states IDLE, RESP, ACK, plus a captured mode bit (mode_q) and a timeout counter (to_cnt).
- IDLE: wake_o = 0. If sync_i is high, capture mode_q = mode_i and go to RESP.
- RESP: wake_o = 1 and error_o = ~mode_q. Always go to ACK after one cycle; ack_i is ignored in this state.
- ACK: wake_o = 1 and error_o = ~mode_q.
  - ack_i high: go to IDLE.
  - Otherwise, if timeout_i ≠ 0 and to_cnt == timeout_i−1: go to IDLE and set to_sticky_o.
  - Otherwise: increment to_cnt.
  - to_cnt is zeroed on entry to ACK.
- Error accounting happens on the IDLE→RESP transition when mode_i = 0: set err_sticky_o and increment err_cnt_o, which saturates at 2^CNT_WIDTH−1.
- sync_i high in RESP or ACK sets proto_sticky_o. That sync is dropped, not queued. This includes a sync in the same cycle as ack_i.
- First-error capture: on the first error acceptance while first_vld_o = 0, latch port index, lvl_i and id_i, and set first_vld_o. If several ports accept errors in the same cycle, the lowest index wins. The capture holds until clear_i.
- clear_i zeroes every sticky bit, counter and capture register. If clear_i coincides with a new event, the event wins: the flag is set, the counter becomes 1, and the capture loads. clear_i does not affect the FSMs.
- Ports are fully independent; no arbitration except first-error capture.

## Timing
- Reset values: all outputs 0, FSMs in IDLE, mode_q = 0, to_cnt = 0.
- Reset asserted mid-operation returns immediately to IDLE and drops wake_o asynchronously.
- sync_i sampled high at edge t gives wake_o high from cycle t+1; error_o, the sticky bits and err_cnt_o also update at t+1.
- wake_o lasts at least 2 cycles (RESP + 1 ACK cycle).
- ack_i sampled in ACK at edge t gives wake_o low at t+1.
- Timeout: with no ack, wake_o stays high for exactly 1 + timeout_i cycles.
- ack_i on the expiry cycle counts as ack: no timeout flag.
- Earliest new acceptance is the cycle after returning to IDLE, so back-to-back barriers take ≥3 cycles each.
- All status outputs are registered. wake_o and error_o are decoded from state only; no combinational path from any input.

## Test plan
- Error mode, port 0, lvl=1, id=1, ack 3 cycles after wake → wake/error high 4 cycles; err_cnt_o[0]=1; first_vld_o=1, port 0, lvl 1, id 1; irq_o=1.
- Root mode, port 1, ack on the first ACK cycle → wake high 2 cycles, error_o=0; no sticky set; irq_o=0.
- timeout_i=4, error mode, no ack → wake high 5 cycles then low; to_sticky_o=1. Repeat with ack on the expiry cycle → to_sticky_o stays 0.
- Simultaneous error syncs on ports 2 and 1 (N_PORTS=4) → first_port_o=1; both err_sticky bits set. Then clear_i together with a new error on port 3 → first_port_o=3, err_cnt_o[3]=1, others 0.
- CNT_WIDTH=2, five error barriers on one port → err_cnt_o saturates at 3. sync_i during ACK → proto_sticky_o set and no extra wake.
- rstn_i asserted during ACK → wake_o drops immediately and all status is 0; a sync after reset is served normally.

Source files
------------

// File: rtl/fractal_sync_root_monitor.sv
// Root monitor of the fractal synchronization tree: per-port wake/error responder
// with ack timeout, sticky status, saturating error counters and first-error capture.
module fractal_sync_root_monitor #(
   parameter  int unsigned N_PORTS   = 2,
   parameter  int unsigned LVL_WIDTH = 1,
   parameter  int unsigned ID_WIDTH  = 1,
   parameter  int unsigned TO_WIDTH  = 8,
   parameter  int unsigned CNT_WIDTH = 8,
   localparam int unsigned IDX_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                                clk_i,
   input  logic                                rstn_i,
   input  logic [N_PORTS-1:0]                  sync_i,
   input  logic [N_PORTS-1:0][LVL_WIDTH-1:0]   lvl_i,
   input  logic [N_PORTS-1:0][ID_WIDTH-1:0]    id_i,
   input  logic [N_PORTS-1:0]                  ack_i,
   output logic [N_PORTS-1:0]                  wake_o,
   output logic [N_PORTS-1:0]                  error_o,
   input  logic [N_PORTS-1:0]                  mode_i,
   input  logic [TO_WIDTH-1:0]                 timeout_i,
   input  logic                                clear_i,
   output logic [N_PORTS-1:0]                  err_sticky_o,
   output logic [N_PORTS-1:0]                  to_sticky_o,
   output logic [N_PORTS-1:0]                  proto_sticky_o,
   output logic [N_PORTS-1:0][CNT_WIDTH-1:0]   err_cnt_o,
   output logic                                first_vld_o,
   output logic [IDX_WIDTH-1:0]                first_port_o,
   output logic [LVL_WIDTH-1:0]                first_lvl_o,
   output logic [ID_WIDTH-1:0]                 first_id_o,
   output logic                                irq_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      ACK  = 2'd2
   } state_e;

   logic [N_PORTS-1:0] busy;
   logic [N_PORTS-1:0] err_ev;
   logic [N_PORTS-1:0] to_ev;
   logic [N_PORTS-1:0] proto_ev;

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      state_e              state_q;
      logic                mode_q;
      logic [TO_WIDTH-1:0] to_cnt_q;
      logic                expire;

      assign expire      = (timeout_i != '0) && (to_cnt_q == timeout_i - TO_WIDTH'(1));
      assign busy[p]     = (state_q != IDLE);
      assign err_ev[p]   = ~busy[p] & sync_i[p] & ~mode_i[p];
      assign proto_ev[p] = busy[p] & sync_i[p];
      assign to_ev[p]    = (state_q == ACK) & ~ack_i[p] & expire;

      // Responses are decoded from state registers only, so reset drops them at once.
      assign wake_o[p]  = busy[p];
      assign error_o[p] = busy[p] & ~mode_q;

      // NOTE: asynchronous reset in the sensitivity list; sequential state uses <= only
      // so every flop samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk_i or negedge rstn_i) begin
         if (!rstn_i) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            to_cnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (sync_i[p]) begin
                     state_q <= RESP;
                     mode_q  <= mode_i[p];
                  end
               end
               RESP: begin
                  state_q  <= ACK;
                  to_cnt_q <= '0;
               end
               ACK: begin
                  if (ack_i[p] || expire) begin
                     state_q <= IDLE;
                  end else begin
                     to_cnt_q <= to_cnt_q + TO_WIDTH'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   logic [N_PORTS-1:0]                err_sticky_d;
   logic [N_PORTS-1:0]                to_sticky_d;
   logic [N_PORTS-1:0]                proto_sticky_d;
   logic [N_PORTS-1:0][CNT_WIDTH-1:0] err_cnt_d;
   logic                              first_vld_d;
   logic [IDX_WIDTH-1:0]              first_port_d;
   logic [LVL_WIDTH-1:0]              first_lvl_d;
   logic [ID_WIDTH-1:0]               first_id_d;
   logic [CNT_WIDTH-1:0]              cnt_base;

   // NOTE: every variable gets a value before any condition, so no latch is inferred.
   always_comb begin
      cnt_base       = '0;
      err_sticky_d   = (clear_i ? '0 : err_sticky_o)   | err_ev;
      to_sticky_d    = (clear_i ? '0 : to_sticky_o)    | to_ev;
      proto_sticky_d = (clear_i ? '0 : proto_sticky_o) | proto_ev;
      first_vld_d    = clear_i ? 1'b0 : first_vld_o;
      first_port_d   = clear_i ? '0   : first_port_o;
      first_lvl_d    = clear_i ? '0   : first_lvl_o;
      first_id_d     = clear_i ? '0   : first_id_o;

      for (int p = 0; p < N_PORTS; p++) begin
         cnt_base     = clear_i ? '0 : err_cnt_o[p];
         err_cnt_d[p] = (err_ev[p] && (cnt_base != '1)) ? cnt_base + CNT_WIDTH'(1) : cnt_base;
      end

      // Descending scan so the lowest erroring port is the last (winning) assignment.
      if (!first_vld_d && (err_ev != '0)) begin
         first_vld_d = 1'b1;
         for (int p = N_PORTS - 1; p >= 0; p--) begin
            if (err_ev[p]) begin
               first_port_d = IDX_WIDTH'(p);
               first_lvl_d  = lvl_i[p];
               first_id_d   = id_i[p];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         err_sticky_o   <= '0;
         to_sticky_o    <= '0;
         proto_sticky_o <= '0;
         err_cnt_o      <= '0;
         first_vld_o    <= 1'b0;
         first_port_o   <= '0;
         first_lvl_o    <= '0;
         first_id_o     <= '0;
      end else begin
         err_sticky_o   <= err_sticky_d;
         to_sticky_o    <= to_sticky_d;
         proto_sticky_o <= proto_sticky_d;
         err_cnt_o      <= err_cnt_d;
         first_vld_o    <= first_vld_d;
         first_port_o   <= first_port_d;
         first_lvl_o    <= first_lvl_d;
         first_id_o     <= first_id_d;
      end
   end

   assign irq_o = |{err_sticky_o, to_sticky_o, proto_sticky_o};

endmodule

// File: tb/tb_fractal_sync_root_monitor.sv
// Bench for fractal_sync_root_monitor: directed scenarios plus randomized traffic
// checked against a cycle-age behavioural model.
module tb_fractal_sync_root_monitor;

   localparam int N  = 4;
   localparam int LW = 2;
   localparam int IW = 3;
   localparam int TW = 8;
   localparam int CW = 2;
   localparam int XW = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic                 clk;
   logic                 rstn;
   logic [N-1:0]         sync, ack, mode, wake, error;
   logic [N-1:0][LW-1:0] lvl;
   logic [N-1:0][IW-1:0] id;
   logic [TW-1:0]        timeout;
   logic                 clear;
   logic [N-1:0]         err_sticky, to_sticky, proto_sticky;
   logic [N-1:0][CW-1:0] err_cnt;
   logic                 first_vld;
   logic [XW-1:0]        first_port;
   logic [LW-1:0]        first_lvl;
   logic [IW-1:0]        first_id;
   logic                 irq;

   int checks   = 0;
   int failures = 0;

   fractal_sync_root_monitor #(
      .N_PORTS(N), .LVL_WIDTH(LW), .ID_WIDTH(IW), .TO_WIDTH(TW), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rstn_i(rstn), .sync_i(sync), .lvl_i(lvl), .id_i(id), .ack_i(ack),
      .wake_o(wake), .error_o(error), .mode_i(mode), .timeout_i(timeout), .clear_i(clear),
      .err_sticky_o(err_sticky), .to_sticky_o(to_sticky), .proto_sticky_o(proto_sticky),
      .err_cnt_o(err_cnt), .first_vld_o(first_vld), .first_port_o(first_port),
      .first_lvl_o(first_lvl), .first_id_o(first_id), .irq_o(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sync  = '0;
      ack   = '0;
      mode  = '0;
      lvl   = '0;
      id    = '0;
      clear = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cycle();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rstn    = 1'b0;
      timeout = '0;
      idle_inputs();
      #12;
      checks++;
      if ({wake, error, err_sticky, to_sticky, proto_sticky} !== '0) begin
         failures++;
         $display("FAIL reset_flags actual=%b required=0", {wake, error, err_sticky, to_sticky, proto_sticky});
      end
      checks++;
      if ({err_cnt, first_vld, first_port, first_lvl, first_id, irq} !== '0) begin
         failures++;
         $display("FAIL reset_status actual=%b required=0", {err_cnt, first_vld, first_port, first_lvl, first_id, irq});
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      cycle();
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL reset_idle_wake actual=%b required=0000", wake);
      end
   endtask

   task automatic test_error_mode();
      sync[0] = 1'b1; mode[0] = 1'b0; lvl[0] = 2'd1; id[0] = 3'd1;
      cycle();
      sync = '0;
      checks++;
      if (err_cnt[0] !== 2'd1 || err_sticky !== 4'b0001) begin
         failures++;
         $display("FAIL err_count actual cnt=%0d sticky=%b required cnt=1 sticky=0001", err_cnt[0], err_sticky);
      end
      checks++;
      if ({first_vld, first_port, first_lvl, first_id, irq} !== {1'b1, 2'd0, 2'd1, 3'd1, 1'b1}) begin
         failures++;
         $display("FAIL err_capture actual vld=%b port=%0d lvl=%0d id=%0d irq=%b required 1/0/1/1/1",
                  first_vld, first_port, first_lvl, first_id, irq);
      end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if ({wake, error} !== {4'b0001, 4'b0001}) begin
            failures++;
            $display("FAIL err_wake_cycle%0d actual wake=%b error=%b required 0001/0001", k, wake, error);
         end
         if (k == 4) ack[0] = 1'b1;
         cycle();
      end
      ack = '0;
      checks++;
      if ({wake, error, to_sticky, proto_sticky} !== '0) begin
         failures++;
         $display("FAIL err_release actual=%b required=0", {wake, error, to_sticky, proto_sticky});
      end
   endtask

   task automatic test_root_mode();
      do_clear();
      checks++;
      if ({irq, err_sticky, err_cnt, first_vld} !== '0) begin
         failures++;
         $display("FAIL clear_status actual=%b required=0", {irq, err_sticky, err_cnt, first_vld});
      end
      sync[1] = 1'b1; mode[1] = 1'b1;
      cycle();
      sync = '0; mode = '0;
      for (int k = 1; k <= 2; k++) begin
         checks++;
         if ({wake, error} !== {4'b0010, 4'b0000}) begin
            failures++;
            $display("FAIL root_wake_cycle%0d actual wake=%b error=%b required 0010/0000", k, wake, error);
         end
         if (k == 2) ack[1] = 1'b1;
         cycle();
      end
      ack = '0;
      checks++;
      if ({wake, err_sticky, to_sticky, proto_sticky, irq} !== '0) begin
         failures++;
         $display("FAIL root_release actual=%b required=0", {wake, err_sticky, to_sticky, proto_sticky, irq});
      end
      // ack held from the sync cycle on: still at least two wake cycles
      sync[1] = 1'b1; mode[1] = 1'b1; ack[1] = 1'b1;
      cycle();
      sync = '0; mode = '0;
      checks++;
      if (wake !== 4'b0010) begin
         failures++;
         $display("FAIL root_early_ack_c1 actual=%b required=0010", wake);
      end
      cycle();
      checks++;
      if (wake !== 4'b0010) begin
         failures++;
         $display("FAIL root_early_ack_c2 actual=%b required=0010", wake);
      end
      cycle();
      ack = '0;
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL root_early_ack_c3 actual=%b required=0000", wake);
      end
   endtask

   task automatic test_timeout();
      timeout = 8'd4;
      sync[2] = 1'b1;
      cycle();
      sync = '0;
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (wake !== 4'b0100) begin
            failures++;
            $display("FAIL to_wake_cycle%0d actual=%b required=0100", k, wake);
         end
         cycle();
      end
      checks++;
      if ({wake, to_sticky} !== {4'b0000, 4'b0100}) begin
         failures++;
         $display("FAIL to_expire actual wake=%b to=%b required 0000/0100", wake, to_sticky);
      end
      do_clear();
      sync[2] = 1'b1;
      cycle();
      sync = '0;
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (wake !== 4'b0100) begin
            failures++;
            $display("FAIL to_ack_wake_cycle%0d actual=%b required=0100", k, wake);
         end
         if (k == 5) ack[2] = 1'b1;
         cycle();
      end
      ack = '0;
      checks++;
      if ({wake, to_sticky} !== '0) begin
         failures++;
         $display("FAIL to_ack_on_expiry actual wake=%b to=%b required 0000/0000", wake, to_sticky);
      end
      timeout = '0;
   endtask

   task automatic test_first_capture();
      do_clear();
      sync = 4'b0110; mode = '0;
      lvl[1] = 2'd2; id[1] = 3'd5; lvl[2] = 2'd3; id[2] = 3'd6;
      cycle();
      sync = '0;
      checks++;
      if ({first_vld, first_port, first_lvl, first_id, err_sticky} !== {1'b1, 2'd1, 2'd2, 3'd5, 4'b0110}) begin
         failures++;
         $display("FAIL first_lowest actual vld=%b port=%0d lvl=%0d id=%0d sticky=%b required 1/1/2/5/0110",
                  first_vld, first_port, first_lvl, first_id, err_sticky);
      end
      clear = 1'b1; sync[3] = 1'b1; lvl[3] = 2'd1; id[3] = 3'd7;
      cycle();
      clear = 1'b0; sync = '0;
      checks++;
      if ({first_vld, first_port, first_lvl, first_id} !== {1'b1, 2'd3, 2'd1, 3'd7}) begin
         failures++;
         $display("FAIL clear_vs_event_capture actual vld=%b port=%0d lvl=%0d id=%0d required 1/3/1/7",
                  first_vld, first_port, first_lvl, first_id);
      end
      checks++;
      if ({err_cnt, err_sticky} !== {8'b01_00_00_00, 4'b1000}) begin
         failures++;
         $display("FAIL clear_vs_event_count actual cnt=%b sticky=%b required 01000000/1000", err_cnt, err_sticky);
      end
      ack = 4'b1110;
      cycle();
      cycle();
      ack = '0;
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL capture_drain actual=%b required=0000", wake);
      end
   endtask

   task automatic test_saturation_proto();
      int exp_cnt;
      do_clear();
      for (int i = 1; i <= 5; i++) begin
         sync[0] = 1'b1; mode[0] = 1'b0;
         cycle();
         sync = '0;
         cycle();
         ack[0] = 1'b1;
         cycle();
         ack = '0;
         exp_cnt = (i < CMAX) ? i : CMAX;
         checks++;
         if (int'(err_cnt[0]) != exp_cnt) begin
            failures++;
            $display("FAIL sat_count_%0d actual=%0d required=%0d", i, err_cnt[0], exp_cnt);
         end
      end
      sync[0] = 1'b1;
      cycle();
      sync = '0;
      cycle();
      sync[0] = 1'b1;
      cycle();
      sync = '0;
      checks++;
      if ({proto_sticky, wake, err_cnt[0]} !== {4'b0001, 4'b0001, 2'd3}) begin
         failures++;
         $display("FAIL proto_in_ack actual proto=%b wake=%b cnt=%0d required 0001/0001/3", proto_sticky, wake, err_cnt[0]);
      end
      sync[0] = 1'b1; ack[0] = 1'b1;
      cycle();
      sync = '0; ack = '0;
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL proto_with_ack actual=%b required=0000", wake);
      end
      cycle();
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL proto_dropped actual=%b required=0000", wake);
      end
   endtask

   task automatic test_reset_mid();
      sync[0] = 1'b1; mode[0] = 1'b0;
      cycle();
      sync = '0;
      cycle();
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async_wake actual=%b required=0000", wake);
      end
      checks++;
      if ({err_sticky, to_sticky, proto_sticky, err_cnt, first_vld, irq} !== '0) begin
         failures++;
         $display("FAIL reset_async_status actual=%b required=0", {err_sticky, to_sticky, proto_sticky, err_cnt, first_vld, irq});
      end
      @(posedge clk);
      #1 rstn = 1'b1;
      sync[0] = 1'b1; mode[0] = 1'b1;
      cycle();
      sync = '0; mode = '0;
      checks++;
      if ({wake, error} !== {4'b0001, 4'b0000}) begin
         failures++;
         $display("FAIL after_reset_serve actual wake=%b error=%b required 0001/0000", wake, error);
      end
      cycle();
      ack[0] = 1'b1;
      cycle();
      ack = '0;
      checks++;
      if (wake !== 4'b0000) begin
         failures++;
         $display("FAIL after_reset_release actual=%b required=0000", wake);
      end
   endtask

   // Model: each port is busy for a number of cycles counted by its age since
   // acceptance; age 0 is the mandatory response cycle, later cycles honour ack/timeout.
   task automatic test_random();
      bit   m_busy[N], m_mode[N], m_err[N], m_to[N], m_pr[N], ev[N];
      int   m_age[N], m_cnt[N];
      bit   m_fv;
      int   m_fp, m_fl, m_fi;
      logic [N-1:0]         e_wake, e_error, e_es, e_ts, e_ps;
      logic [N-1:0][CW-1:0] e_cnt;
      int   tmo;

      rstn = 1'b0;
      idle_inputs();
      timeout = '0;
      #3;
      @(posedge clk);
      #1 rstn = 1'b1;
      for (int p = 0; p < N; p++) begin
         m_busy[p] = 0; m_mode[p] = 0; m_err[p] = 0; m_to[p] = 0; m_pr[p] = 0;
         m_age[p] = 0; m_cnt[p] = 0;
      end
      m_fv = 0; m_fp = 0; m_fl = 0; m_fi = 0;

      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 60 == 0) timeout = TW'($urandom_range(0, 5));
         for (int p = 0; p < N; p++) begin
            sync[p] = ($urandom_range(0, 99) < 45);
            ack[p]  = ($urandom_range(0, 99) < 40);
            mode[p] = $urandom_range(0, 1) == 1;
            lvl[p]  = LW'($urandom);
            id[p]   = IW'($urandom);
         end
         clear = ($urandom_range(0, 99) < 5);
         tmo   = int'(timeout);

         @(posedge clk);
         if (clear) begin
            for (int p = 0; p < N; p++) begin
               m_err[p] = 0; m_to[p] = 0; m_pr[p] = 0; m_cnt[p] = 0;
            end
            m_fv = 0; m_fp = 0; m_fl = 0; m_fi = 0;
         end
         for (int p = 0; p < N; p++) begin
            ev[p] = 0;
            if (!m_busy[p]) begin
               if (sync[p]) begin
                  m_busy[p] = 1; m_age[p] = 0; m_mode[p] = mode[p];
                  if (!mode[p]) begin
                     ev[p] = 1; m_err[p] = 1;
                     m_cnt[p] = (m_cnt[p] < CMAX) ? m_cnt[p] + 1 : CMAX;
                  end
               end
            end else begin
               if (sync[p]) m_pr[p] = 1;
               if (m_age[p] >= 1 && ack[p]) m_busy[p] = 0;
               else if (m_age[p] >= 1 && tmo != 0 && m_age[p] == tmo) begin
                  m_busy[p] = 0; m_to[p] = 1;
               end else m_age[p]++;
            end
         end
         for (int p = 0; p < N; p++) begin
            if (!m_fv && ev[p]) begin
               m_fv = 1; m_fp = p; m_fl = int'(lvl[p]); m_fi = int'(id[p]);
            end
         end
         #1;
         clear = 1'b0;

         for (int p = 0; p < N; p++) begin
            e_wake[p]  = m_busy[p];
            e_error[p] = m_busy[p] & ~m_mode[p];
            e_es[p]    = m_err[p];
            e_ts[p]    = m_to[p];
            e_ps[p]    = m_pr[p];
            e_cnt[p]   = CW'(m_cnt[p]);
         end
         checks++;
         if ({wake, error} !== {e_wake, e_error}) begin
            failures++;
            $display("FAIL rnd_resp cyc=%0d actual wake=%b error=%b required %b/%b", cyc, wake, error, e_wake, e_error);
         end
         checks++;
         if ({err_sticky, to_sticky, proto_sticky, irq} !== {e_es, e_ts, e_ps, |{e_es, e_ts, e_ps}}) begin
            failures++;
            $display("FAIL rnd_sticky cyc=%0d actual err=%b to=%b proto=%b irq=%b required %b/%b/%b",
                     cyc, err_sticky, to_sticky, proto_sticky, irq, e_es, e_ts, e_ps);
         end
         checks++;
         if (err_cnt !== e_cnt) begin
            failures++;
            $display("FAIL rnd_count cyc=%0d actual=%b required=%b", cyc, err_cnt, e_cnt);
         end
         checks++;
         if ({first_vld, first_port, first_lvl, first_id} !== {m_fv, XW'(m_fp), LW'(m_fl), IW'(m_fi)}) begin
            failures++;
            $display("FAIL rnd_capture cyc=%0d actual vld=%b port=%0d lvl=%0d id=%0d required %b/%0d/%0d/%0d",
                     cyc, first_vld, first_port, first_lvl, first_id, m_fv, m_fp, m_fl, m_fi);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_error_mode();
      test_root_mode();
      test_timeout();
      test_first_capture();
      test_saturation_proto();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
